muldiv_controller: RTL

Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the MIPS32 core. Issue logic starts it for mult, multu, div and divu. It runs a radix-2 shift-add or restoring-divide loop over 32 cycles, applies sign correction and writes HI/LO. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo, alongside the single-cycle ALU in the EX stage.

---
 rtl/muldiv_controller.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_controller.sv
// Multi-cycle multiply/divide sequencer owning the MIPS32 HI/LO pair (radix-2, 32 steps).
// Define MULDIV_DIV_EN to build the restoring divider; without it div/divu complete at once with illegal set.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic             is_div;
  logic             prod_neg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opb;

  logic             signed_op;
  logic             accept;

  // Two's-complement magnitude for signed ops; unsigned ops pass through.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] negx;
    negx = -x;
    if (sgn && x[WIDTH-1])
      magnitude = $unsigned(negx);
    else
      magnitude = $unsigned(x);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    cond_neg = n ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x,
                                                       input logic n);
    cond_neg_wide = n ? (~x + 1'b1) : x;
  endfunction

  assign signed_op = ~op[0];
  assign accept    = (state == IDLE) && start;

  // Multiply step: conditional add of the multiplicand, then shift {acc, mq} right.
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   mul_acc;
  logic [WIDTH-1:0]   mul_mq;
  logic [2*WIDTH-1:0] prod;

  assign add_sum = {1'b0, acc} + (mq[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_acc = add_sum[WIDTH:1];
  assign mul_mq  = {add_sum[0], mq[WIDTH-1:1]};
  assign prod    = cond_neg_wide({acc, mq}, prod_neg);

`ifdef MULDIV_DIV_EN
  logic             rem_neg;
  logic [WIDTH-1:0] rs_orig;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_mq;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             dz;

  // Remainder stays below the divisor, so bit WIDTH of the trial is exactly the borrow.
  assign shifted = {acc, mq[WIDTH-1]};
  assign trial   = shifted - {1'b0, opb};
  assign fits    = ~trial[WIDTH];
  assign div_acc = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign div_mq  = {mq[WIDTH-2:0], fits};
  assign quot    = cond_neg(mq, prod_neg);
  assign rem     = cond_neg(acc, rem_neg);
  assign dz      = (opb == '0);
`endif

  // Operand and accumulator registers carry no reset; control below qualifies them.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div   <= op[1];
      prod_neg <= signed_op & (rs[WIDTH-1] ^ rt[WIDTH-1]);
      acc      <= '0;
      mq       <= magnitude(rs, signed_op);
      opb      <= magnitude(rt, signed_op);
`ifdef MULDIV_DIV_EN
      rem_neg  <= signed_op & rs[WIDTH-1];
      rs_orig  <= rs;
`endif
    end else if (state == CALC) begin
`ifdef MULDIV_DIV_EN
      if (is_div) begin
        acc <= div_acc;
        mq  <= div_mq;
      end else
`endif
      begin
        acc <= mul_acc;
        mq  <= mul_mq;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
            state <= CALC;
`else
            state <= op[1] ? FIX : CALC;
`endif
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - 1'b1;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div) begin
`ifdef MULDIV_DIV_EN
            if (dz) begin
              lo          <= '1;
              hi          <= rs_orig;
              div_by_zero <= 1'b1;
            end else begin
              lo <= quot;
              hi <= rem;
            end
`else
            illegal <= 1'b1;
`endif
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
